// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction fetch front end of the multicycle core.
// Issues sequential word addresses to a 1-cycle synchronous-read instruction
// memory and buffers each returned word with its PC in a DEPTH-entry FIFO.
// Words are handed to decode over a valid/ready handshake. A redirect
// flushes buffered and in-flight words and restarts fetch. Fetch stops once
// a HALT word (imem_data[30:27] == 4'b1111) has been captured.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   imem_en, imem_addr     memory read request (word aligned byte address)
//   imem_data              memory read data, valid the cycle after imem_en
//   instr, instr_pc        head-of-FIFO word and its byte address
//   instr_valid            FIFO non-empty
//   instr_ready            consumer accepts head this cycle
//   redirect, redirect_pc  branch taken: flush and restart at redirect_pc
//   halted                 HALT fetched, FIFO drained, nothing in flight
//   fetch_cnt, flush_cnt   (IF_PERF_CNT_EN only) words pushed / redirects
//
// Optional feature macro: IF_PERF_CNT_EN
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic          halt_seen;
  logic [31:0]   last_instr;
  logic [31:0]   last_pc;

  logic [PW-1:0] count;
  logic [PW:0]   used;
  logic          do_redirect;
  logic          issue;
  logic          push;
  logic          pop;
  logic          is_halt;
  logic [AW-1:0] head;

  always_comb begin
    count       = wr_ptr - rd_ptr;
    used        = {1'b0, count} + {{PW{1'b0}}, inflight};
    do_redirect = rst && redirect;
    issue       = do_redirect ||
                  (rst && !halt_seen && (used < (PW + 1)'(DEPTH)));
    imem_en     = issue;
    imem_addr   = do_redirect ? {redirect_pc[31:2], 2'b00} : fetch_pc;
    is_halt     = (imem_data[30:27] == 4'b1111);
    // Once HALT is captured, the word issued alongside it is dropped so
    // nothing past the HALT is ever presented.
    push        = inflight && !redirect && !halt_seen;
    instr_valid = (count != '0);
    pop         = instr_valid && instr_ready && !redirect;
    head        = rd_ptr[AW-1:0];
    // When empty, outputs hold the last head value presented.
    instr       = instr_valid ? fifo_instr[head] : last_instr;
    instr_pc    = instr_valid ? fifo_pc[head]    : last_pc;
    halted      = halt_seen && (count == '0) && !inflight;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr[AW-1:0]] <= imem_data;
      fifo_pc[wr_ptr[AW-1:0]]    <= inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      halt_seen   <= 1'b0;
      last_instr  <= '0;
      last_pc     <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= imem_addr + 32'd4;
        inflight_pc <= imem_addr;
      end
      if (redirect) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        halt_seen <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && is_halt) halt_seen <= 1'b1;
      end
      if (instr_valid) begin
        last_instr <= fifo_instr[head];
        last_pc    <= fifo_pc[head];
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push)     fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch (DEPTH=4, RESET_PC=0).
// A behavioural 1-cycle memory returns 32'h0100_0000 + word index, or a HALT
// word at a chosen address. Expected {pc, word} pairs are queued as each
// directed step is driven and compared whenever the DUT hands off a word.
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halted(halted)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h8;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && a == halt_addr) return 32'h7800_0000;
    return 32'h0100_0000 + (a >> 2);
  endfunction

  always @(posedge clk) if (imem_en) imem_data <= mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every accepted hand-off must match the queue head.
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready && !redirect) begin
      check("pop_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc", instr_pc, e.pc);
        check("pop_instr", instr, e.word);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: a, word: mem_word(a)});
      a = a + 32'd4;
    end
  endtask

  // Release reset (this cycle is cycle 0) and stream n words with ready=1.
  task automatic start_after_reset(input int n);
    rst = 1'b1;
    instr_ready = 1'b1;
    push_exp(32'h0, n);
    @(negedge clk);
    check("c0_imem_en", 32'(imem_en), 32'd1);
    check("c0_imem_addr", imem_addr, 32'h0);
    check("c0_valid", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    check("c1_valid", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    check("c2_valid", 32'(instr_valid), 32'd1);
    check("c2_pc", instr_pc, 32'h0);
    repeat (n) tick();
    instr_ready = 1'b0;
  endtask

  // Redirect in cycle t, then accept exactly n target words (n >= 1).
  task automatic do_redirect(input logic [31:0] pc, input int n);
    logic [31:0] tgt;
    tgt = {pc[31:2], 2'b00};
    redirect = 1'b1;
    redirect_pc = pc;
    instr_ready = 1'b1;
    push_exp(tgt, n);
    @(negedge clk);
    check("redir_imem_en", 32'(imem_en), 32'd1);
    check("redir_imem_addr", imem_addr, tgt);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_t1_valid", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    check("redir_t2_valid", 32'(instr_valid), 32'd1);
    check("redir_t2_pc", instr_pc, tgt);
    repeat (n) tick();
    instr_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_en"}, 32'(imem_en), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
`ifdef IF_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    tick();

    // Stream PCs 0..20, then stall: FIFO fills to 4 with 24 at the head.
    start_after_reset(6);
    repeat (9) tick();
    @(negedge clk);
    check("full_imem_en", 32'(imem_en), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_head_pc", instr_pc, 32'd24);
    tick();
    instr_ready = 1'b1;
    push_exp(32'd24, 4);
    repeat (4) tick();
    instr_ready = 1'b0;
    tick();

    // FIFO holds 3 entries with one in flight; redirect to an unaligned PC.
    do_redirect(32'h43, 3);

    // HALT at PC 8: nothing past it is presented and halted rises.
    halt_en = 1'b1;
    do_redirect(32'h0, 3);
    @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_imem_en", 32'(imem_en), 32'd0);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_hold_pc", instr_pc, 32'h8);
    instr_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("halt_stays", 32'(halted), 32'd1);
    check("halt_no_fetch", 32'(imem_en), 32'd0);
    tick();
    instr_ready = 1'b0;
    halt_en = 1'b0;
    do_redirect(32'h0, 2);
    @(negedge clk);
    check("resume_halted", 32'(halted), 32'd0);
    tick();

    // Address wrap at the top of memory.
    do_redirect(32'hFFFF_FFF8, 4);
    tick();

    // Reset mid-stream with a read in flight.
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    start_after_reset(3);
    repeat (2) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
